// File: rtl/hub_pkg.sv
// Shared types and helpers for the hub memory port: bus sizes, slot count and
// byte-lane enable generation.
package hub_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      WORD = 2'b01,
      LONG = 2'b10
   } bus_size_t;

   localparam int NUMSLOTS      = 8;
   localparam int MEM_LONGS_DEF = 8192;

   // Size 2'b11 is treated as a long, matching the 1x encoding on bus_s.
   function automatic logic [3:0] size_to_be(input logic [1:0] size, input logic [1:0] a10);
      if (size[1])
         return 4'b1111;
      else if (size == WORD)
         return a10[1] ? 4'b1100 : 4'b0011;
      else
         return 4'b0001 << a10;
   endfunction

endpackage

// File: rtl/hub_mem_port_if.sv
// Cog<->hub bus: slot rotation and responses come from the hub, requests from
// the cog that owns the current slot.
interface hub_mem_port_if;
   import hub_pkg::*;

   logic                ena_bus;
   logic [NUMSLOTS-1:0] bus_sel;
   logic                bus_r;
   logic                bus_e;
   logic                bus_w;
   logic [1:0]          bus_s;
   logic [15:0]         bus_a;
   logic [31:0]         bus_d;
   logic [31:0]         bus_q;
   logic                bus_c;
   logic [NUMSLOTS-1:0] bus_ack;

   modport master (
      input  ena_bus, bus_sel, bus_q, bus_c, bus_ack,
      output bus_r, bus_e, bus_w, bus_s, bus_a, bus_d
   );

   modport slave (
      output ena_bus, bus_sel, bus_q, bus_c, bus_ack,
      input  bus_r, bus_e, bus_w, bus_s, bus_a, bus_d
   );

endinterface

// File: rtl/hub_ram.sv
// Single-port hub RAM with four byte lanes, per-lane write enable and a
// registered read port. Contents survive reset.
module hub_ram #(
   parameter  int DEPTH = 8192,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_cog,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk_cog) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i])
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/hub_mem_port.sv
// Hub-side responder: drives the 8-slot rotation, samples the selected cog's
// request, services it against hub RAM and returns a one-cycle-latency response.
module hub_mem_port
   import hub_pkg::*;
#(
   parameter int MEM_LONGS = MEM_LONGS_DEF,
   parameter int NUMCOGS   = 8
) (
   input  logic           clk_cog,
   input  logic           nres,
   hub_mem_port_if.slave  bus
);

   localparam int AW = $clog2(MEM_LONGS);
   localparam logic [NUMSLOTS-1:0] COG_MASK = NUMSLOTS'((64'd1 << NUMCOGS) - 64'd1);

   logic                ena_bus;
   logic [NUMSLOTS-1:0] bus_sel;
   logic [NUMSLOTS-1:0] ack_q;
   logic [31:0]         q_q;
   logic                c_q;

   logic                vld_p0;
   logic [3:0]          ram_we_p0;
   logic                ram_en_p0;
   logic [31:0]         ram_wdata_p0;

   logic                vld_p1;
   logic [NUMSLOTS-1:0] slot_p1;
   logic [1:0]          size_p1;
   logic [1:0]          a10_p1;
   logic                wr_p1;
   logic                hub_p1;
   logic [31:0]         rdata_p1;

   logic                unused_addr;

   function automatic logic [31:0] place_wdata(input logic [1:0] size, input logic [31:0] d);
      if (size[1])
         return d;
      else if (size == WORD)
         return {2{d[15:0]}};
      else
         return {4{d[7:0]}};
   endfunction

   function automatic logic [31:0] read_response(input logic hub, input logic wr,
                                                 input logic [1:0] size, input logic [1:0] a10,
                                                 input logic [31:0] rdata);
      if (hub || wr)
         return '0;
      else if (size[1])
         return rdata;
      else if (size == WORD)
         return {16'b0, a10[1] ? rdata[31:16] : rdata[15:0]};
      else
         return {24'b0, rdata[8*a10 +: 8]};
   endfunction

   // Stage p0: request sampling and RAM access on the ena_bus=1 edge
   assign vld_p0       = ena_bus && (|bus_sel) && (bus.bus_r || bus.bus_e);
   assign ram_en_p0    = vld_p0 && !bus.bus_e;
   assign ram_we_p0    = (ram_en_p0 && bus.bus_w) ? size_to_be(bus.bus_s, bus.bus_a[1:0]) : 4'b0000;
   assign ram_wdata_p0 = place_wdata(bus.bus_s, bus.bus_d);
   assign unused_addr  = ^bus.bus_a[15:AW+2];

   hub_ram #(
      .DEPTH (MEM_LONGS)
   ) u_ram (
      .clk_cog (clk_cog),
      .en      (ram_en_p0),
      .we      (ram_we_p0),
      .addr    (bus.bus_a[AW+1:2]),
      .wdata   (ram_wdata_p0),
      .rdata   (rdata_p1)
   );

   // Stage p1: captured request, response launched on the following ena_bus=0 edge
   always_ff @(posedge clk_cog or negedge nres) begin
      if (!nres) begin
         ena_bus <= 1'b0;
         bus_sel <= '0;
         vld_p1  <= 1'b0;
         slot_p1 <= '0;
         size_p1 <= 2'b00;
         a10_p1  <= 2'b00;
         wr_p1   <= 1'b0;
         hub_p1  <= 1'b0;
         ack_q   <= '0;
         q_q     <= '0;
         c_q     <= 1'b0;
      end else begin
         ena_bus <= !ena_bus;
         if (ena_bus) begin
            bus_sel <= {bus_sel[NUMSLOTS-2:0], ~|bus_sel[NUMSLOTS-2:0]};
            vld_p1  <= vld_p0;
            slot_p1 <= bus_sel;
            size_p1 <= bus.bus_s;
            a10_p1  <= bus.bus_a[1:0];
            wr_p1   <= bus.bus_w;
            hub_p1  <= bus.bus_e;
         end else if (vld_p1) begin
            ack_q <= slot_p1 & COG_MASK;
            q_q   <= read_response(hub_p1, wr_p1, size_p1, a10_p1, rdata_p1);
            c_q   <= hub_p1;
         end else begin
            ack_q <= '0;
            q_q   <= '0;
            c_q   <= 1'b0;
         end
      end
   end

   assign bus.ena_bus = ena_bus;
   assign bus.bus_sel = bus_sel;
   assign bus.bus_ack = ack_q;
   assign bus.bus_q   = q_q;
   assign bus.bus_c   = c_q;

endmodule

// File: tb/tb_hub_mem_port.sv
// Bench for hub_mem_port: slot rotation, table of directed accesses, corner
// sequences and random traffic against a byte-array memory model.
module tb_hub_mem_port;
   import hub_pkg::*;

   logic clk_cog = 1'b0;
   logic nres    = 1'b1;

   always #5 clk_cog = ~clk_cog;

   hub_mem_port_if bus_if ();

   hub_mem_port #(
      .MEM_LONGS (8192),
      .NUMCOGS   (8)
   ) dut (
      .clk_cog (clk_cog),
      .nres    (nres),
      .bus     (bus_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] ref_mem [32768];

   typedef struct {
      int          slot;
      bit          r;
      bit          e;
      bit          w;
      logic [1:0]  s;
      logic [15:0] a;
      logic [31:0] d;
      logic [31:0] q;
      bit          c;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   // Memory model: 15-bit byte address space, lanes chosen from size/offset.
   task automatic ref_access(input bit e, input bit w, input logic [1:0] s, input logic [15:0] a,
                             input logic [31:0] d, output logic [31:0] q, output bit c);
      int base, start, nbytes;
      q = 32'h0;
      c = 1'b0;
      if (e) begin
         c = 1'b1;
         return;
      end
      base   = int'(a & 16'h7FFC);
      nbytes = s[1] ? 4 : (s[0] ? 2 : 1);
      start  = s[1] ? 0 : (s[0] ? int'(a & 16'h0002) : int'(a & 16'h0003));
      for (int i = 0; i < nbytes; i++) begin
         if (w) ref_mem[base + start + i] = d[8*i +: 8];
         else   q[8*i +: 8] = ref_mem[base + start + i];
      end
   endtask

   task automatic drive_idle();
      bus_if.bus_r = 1'b0;
      bus_if.bus_e = 1'b0;
      bus_if.bus_w = 1'b0;
      bus_if.bus_s = 2'b00;
      bus_if.bus_a = 16'h0;
      bus_if.bus_d = 32'h0;
   endtask

   // Waits for the slot, issues one request and checks the 2-cycle response.
   task automatic do_req(input int slot, input bit r, input bit e, input bit w, input logic [1:0] s,
                         input logic [15:0] a, input logic [31:0] d,
                         input logic [31:0] exp_q, input bit exp_c, input string tag);
      int waited;
      logic [7:0] exp_ack;
      waited  = 0;
      exp_ack = 8'(1 << slot);
      @(negedge clk_cog);
      while (!(bus_if.ena_bus === 1'b1 && bus_if.bus_sel === exp_ack) && waited < 40) begin
         @(negedge clk_cog);
         waited++;
      end
      if (waited >= 40) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s slot_wait: slot %0d never selected, got sel %02h", tag, slot, bus_if.bus_sel);
         return;
      end
      bus_if.bus_r = r;
      bus_if.bus_e = e;
      bus_if.bus_w = w;
      bus_if.bus_s = s;
      bus_if.bus_a = a;
      bus_if.bus_d = d;
      @(posedge clk_cog);
      #1;
      drive_idle();
      for (int k = 0; k < 2; k++) begin
         @(posedge clk_cog);
         #1;
         check({tag, " ack"}, 32'(bus_if.bus_ack), 32'(exp_ack));
         check({tag, " q"},   bus_if.bus_q, exp_q);
         check({tag, " c"},   32'(bus_if.bus_c), 32'(exp_c));
      end
      @(posedge clk_cog);
      #1;
      check({tag, " ack_drop"}, 32'(bus_if.bus_ack), 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] eq;
      bit          ec;
      logic [7:0]  exp_sel;
      int          waited;

      vecs[0]  = '{3, 1, 0, 1, 2'b10, 16'h0104, 32'hDEADBEEF, 32'h00000000, 0};
      vecs[1]  = '{5, 1, 0, 0, 2'b10, 16'h0104, 32'h00000000, 32'hDEADBEEF, 0};
      vecs[2]  = '{1, 1, 0, 1, 2'b00, 16'h0106, 32'h0000005A, 32'h00000000, 0};
      vecs[3]  = '{2, 1, 0, 0, 2'b01, 16'h0106, 32'h12345678, 32'h0000DE5A, 0};
      vecs[4]  = '{4, 1, 0, 0, 2'b00, 16'h0107, 32'h00000000, 32'h000000DE, 0};
      vecs[5]  = '{6, 1, 0, 1, 2'b10, 16'h8000, 32'h11223344, 32'h00000000, 0};
      vecs[6]  = '{7, 1, 0, 0, 2'b10, 16'h0000, 32'h00000000, 32'h11223344, 0};
      vecs[7]  = '{0, 1, 1, 1, 2'b10, 16'h0000, 32'hFFFFFFFF, 32'h00000000, 1};
      vecs[8]  = '{1, 1, 0, 0, 2'b10, 16'h0000, 32'h00000000, 32'h11223344, 0};
      vecs[9]  = '{0, 1, 0, 1, 2'b10, 16'h0100, 32'h55667788, 32'h00000000, 0};
      vecs[10] = '{2, 1, 0, 1, 2'b01, 16'h0102, 32'hABCD1234, 32'h00000000, 0};
      vecs[11] = '{3, 1, 0, 0, 2'b11, 16'h0100, 32'h00000000, 32'h12347788, 0};
      vecs[12] = '{4, 1, 0, 0, 2'b01, 16'h0100, 32'h00000000, 32'h00007788, 0};
      vecs[13] = '{5, 1, 0, 0, 2'b00, 16'h0101, 32'h00000000, 32'h00000077, 0};
      vecs[14] = '{7, 0, 1, 0, 2'b00, 16'h0000, 32'h00000000, 32'h00000000, 1};

      drive_idle();
      #2 nres = 1'b0;
      repeat (3) @(posedge clk_cog);
      #1;
      check("reset ena_bus", 32'(bus_if.ena_bus), 32'h0);
      check("reset bus_sel", 32'(bus_if.bus_sel), 32'h0);
      check("reset bus_ack", 32'(bus_if.bus_ack), 32'h0);
      check("reset bus_q",   bus_if.bus_q, 32'h0);
      check("reset bus_c",   32'(bus_if.bus_c), 32'h0);

      // A request present while bus_sel is still zero must be ignored.
      bus_if.bus_r = 1'b1;
      @(negedge clk_cog);
      nres = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk_cog);
         #1;
         if (n == 2) drive_idle();
         exp_sel = (n < 2) ? 8'h00 : 8'(1 << (((n - 2) / 2) % 8));
         check($sformatf("rot ena n=%0d", n), 32'(bus_if.ena_bus), 32'(n % 2));
         check($sformatf("rot sel n=%0d", n), 32'(bus_if.bus_sel), 32'(exp_sel));
         check($sformatf("rot ack n=%0d", n), 32'(bus_if.bus_ack), 32'h0);
      end

      for (int i = 0; i < 15; i++) begin
         do_req(vecs[i].slot, vecs[i].r, vecs[i].e, vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d,
                vecs[i].q, vecs[i].c, $sformatf("vec%0d", i));
      end

      // Read-after-write in back-to-back slots: write sampled at E, read at E+2.
      waited = 0;
      @(negedge clk_cog);
      while (!(bus_if.ena_bus === 1'b1 && bus_if.bus_sel === 8'h04) && waited < 40) begin
         @(negedge clk_cog);
         waited++;
      end
      bus_if.bus_r = 1'b1;
      bus_if.bus_w = 1'b1;
      bus_if.bus_s = 2'b10;
      bus_if.bus_a = 16'h0300;
      bus_if.bus_d = 32'hCAFEF00D;
      @(posedge clk_cog);
      #1;
      drive_idle();
      @(posedge clk_cog);
      #1;
      check("raw write ack", 32'(bus_if.bus_ack), 32'h04);
      @(negedge clk_cog);
      bus_if.bus_r = 1'b1;
      bus_if.bus_s = 2'b10;
      bus_if.bus_a = 16'h0300;
      @(posedge clk_cog);
      #1;
      drive_idle();
      check("raw write ack hold", 32'(bus_if.bus_ack), 32'h04);
      @(posedge clk_cog);
      #1;
      check("raw read ack", 32'(bus_if.bus_ack), 32'h08);
      check("raw read q",   bus_if.bus_q, 32'hCAFEF00D);

      // Reset right after a read is sampled: response must never appear.
      waited = 0;
      @(negedge clk_cog);
      while (!(bus_if.ena_bus === 1'b1 && bus_if.bus_sel === 8'h20) && waited < 40) begin
         @(negedge clk_cog);
         waited++;
      end
      bus_if.bus_r = 1'b1;
      bus_if.bus_s = 2'b10;
      bus_if.bus_a = 16'h0104;
      @(posedge clk_cog);
      #1;
      drive_idle();
      #1 nres = 1'b0;
      #1;
      check("midrst ena_bus", 32'(bus_if.ena_bus), 32'h0);
      check("midrst bus_sel", 32'(bus_if.bus_sel), 32'h0);
      check("midrst bus_ack", 32'(bus_if.bus_ack), 32'h0);
      check("midrst bus_q",   bus_if.bus_q, 32'h0);
      check("midrst bus_c",   32'(bus_if.bus_c), 32'h0);
      repeat (2) begin
         @(posedge clk_cog);
         #1;
         check("midrst no ack", 32'(bus_if.bus_ack), 32'h0);
      end
      @(negedge clk_cog);
      nres = 1'b1;
      do_req(1, 1, 0, 0, 2'b10, 16'h0104, 32'h0, 32'hDE5ABEEF, 0, "post_reset reread");

      // Random traffic over a pre-filled window, with aliases through bit 15.
      for (int k = 0; k < 16; k++) begin
         logic [15:0] a;
         logic [31:0] d;
         a = 16'(16'h0200 + 4 * k);
         d = $urandom;
         ref_access(0, 1, 2'b10, a, d, eq, ec);
         do_req(k % 8, 1, 0, 1, 2'b10, a, d, eq, ec, $sformatf("fill%0d", k));
      end
      for (int k = 0; k < 48; k++) begin
         int          kind, slot;
         bit          r, e, w;
         logic [1:0]  s;
         logic [15:0] a;
         logic [31:0] d;
         kind = $urandom_range(7, 0);
         slot = $urandom_range(7, 0);
         e    = (kind == 0);
         w    = (kind >= 1 && kind <= 3) || (e && $urandom_range(1, 0) == 1);
         r    = e ? ($urandom_range(1, 0) == 1) : 1'b1;
         s    = 2'($urandom_range(3, 0));
         a    = 16'(16'h0200 + $urandom_range(63, 0));
         if ($urandom_range(1, 0) == 1) a = a | 16'h8000;
         d    = $urandom;
         ref_access(e, w, s, a, d, eq, ec);
         do_req(slot, r, e, w, s, a, d, eq, ec, $sformatf("rnd%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
